ni_link_adapter: RTL and testbench

//  Router-facing end of the NI. Sinks NI egress writes {ni_waddr, ni_wdata} and emits each as a 2-flit

---
 rtl/ni_link_adapter_pkg.sv | 23 ++
 rtl/ni_link_adapter_fifo.sv | 53 +++++
 rtl/ni_link_adapter.sv | 148 ++++++++++++++
 tb/tb_ni_link_adapter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_link_adapter_pkg.sv
// Shared flit types, FSM state encodings and sizing helper
// for the NI router-link adapter.
package ni_link_adapter_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEAD,
    TX_TAIL
  } tx_state_e;

  typedef enum logic {
    RX_WAIT_HEAD,
    RX_WAIT_TAIL
  } rx_state_e;

  function automatic int word_bits(input int msb_slot);
    return 1 << (msb_slot - 1);
  endfunction

endpackage

// File: rtl/ni_link_adapter_fifo.sv
// First-word-fall-through synchronous FIFO; the head word
// reads as zero while empty. A push into a full FIFO is dropped.
module ni_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int ADDRSIZE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] CNT_FULL = (ADDRSIZE + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDRSIZE-1:0] r_wptr;
  logic [ADDRSIZE-1:0] r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic                w_push;
  logic                w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/ni_link_adapter.sv
// Router-facing NI end: egress words become HEAD+TAIL flit
// pairs; incoming pairs are reassembled into the ingress FIFO.
module ni_link_adapter
  import ni_link_adapter_pkg::*;
#(
  parameter  int MSB_SLOT = 5,
  parameter  int ADDRSIZE = 2,
  localparam int RSIZE    = 1 << (MSB_SLOT - 1),
  localparam int FLIT_W   = RSIZE + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ni_write_en,
  input  logic [RSIZE-1:0]  ni_waddr,
  input  logic [RSIZE-1:0]  ni_wdata,
  output logic              ni_wfull,
  input  logic              ni_read_en,
  output logic [RSIZE-1:0]  ni_rdata,
  output logic              ni_rempty,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        err_count
);

  tx_state_e          r_tx_state, w_tx_next;
  rx_state_e          r_rx_state, w_rx_next;
  logic [RSIZE-1:0]   r_tx_addr;
  logic [RSIZE-1:0]   r_tx_data;
  logic [2*RSIZE-1:0] w_eg_rdata;
  logic               w_eg_empty;
  logic               w_eg_pop;
  logic               w_in_full;
  logic               w_in_push;
  logic               w_rx_xfer;
  logic               w_err;
  logic [1:0]         w_rx_type;

  ni_sync_fifo #(.WIDTH(2*RSIZE), .ADDRSIZE(ADDRSIZE)) u_egress (
    .clk   (clk),
    .reset (reset),
    .push  (ni_write_en),
    .wdata ({ni_waddr, ni_wdata}),
    .pop   (w_eg_pop),
    .rdata (w_eg_rdata),
    .full  (ni_wfull),
    .empty (w_eg_empty)
  );

  ni_sync_fifo #(.WIDTH(RSIZE), .ADDRSIZE(ADDRSIZE)) u_ingress (
    .clk   (clk),
    .reset (reset),
    .push  (w_in_push),
    .wdata (rx_flit[RSIZE-1:0]),
    .pop   (ni_read_en),
    .rdata (ni_rdata),
    .full  (w_in_full),
    .empty (ni_rempty)
  );

  always_comb begin
    w_tx_next = r_tx_state;
    w_eg_pop  = 1'b0;
    tx_valid  = 1'b0;
    tx_flit   = '0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (!w_eg_empty) begin
          w_eg_pop  = 1'b1;
          w_tx_next = TX_HEAD;
        end
      end
      TX_HEAD: begin
        tx_valid = 1'b1;
        tx_flit  = {FLIT_HEAD, r_tx_addr};
        if (tx_ready) w_tx_next = TX_TAIL;
      end
      TX_TAIL: begin
        tx_valid = 1'b1;
        tx_flit  = {FLIT_TAIL, r_tx_data};
        if (tx_ready) begin
          w_eg_pop  = !w_eg_empty;
          w_tx_next = w_eg_empty ? TX_IDLE : TX_HEAD;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_addr  <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_eg_pop) begin
        r_tx_addr <= w_eg_rdata[2*RSIZE-1:RSIZE];
        r_tx_data <= w_eg_rdata[RSIZE-1:0];
      end
    end
  end

  // HEAD payload is not forwarded; only TAIL data reaches the NI.
  assign w_rx_type = rx_flit[FLIT_W-1:RSIZE];
  assign w_rx_xfer = rx_valid && rx_ready;

  always_comb begin
    w_rx_next = r_rx_state;
    rx_ready  = 1'b1;
    w_in_push = 1'b0;
    w_err     = 1'b0;
    unique case (r_rx_state)
      RX_WAIT_HEAD: begin
        if (w_rx_xfer) begin
          if (w_rx_type == FLIT_HEAD) w_rx_next = RX_WAIT_TAIL;
          else                        w_err     = 1'b1;
        end
      end
      RX_WAIT_TAIL: begin
        rx_ready = !w_in_full;
        if (w_rx_xfer) begin
          if (w_rx_type == FLIT_TAIL) begin
            w_in_push = 1'b1;
            w_rx_next = RX_WAIT_HEAD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: w_rx_next = RX_WAIT_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_WAIT_HEAD;
      err_count  <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ni_link_adapter.sv
// Self-checking bench for ni_link_adapter: directed scenarios
// plus a randomized run against a queue-based link model.
module tb_ni_link_adapter;

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] TL = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ni_write_en;
  logic [15:0] ni_waddr;
  logic [15:0] ni_wdata;
  logic        ni_wfull;
  logic        ni_read_en;
  logic [15:0] ni_rdata;
  logic        ni_rempty;
  logic [17:0] tx_flit;
  logic        tx_valid;
  logic        tx_ready;
  logic [17:0] rx_flit;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];
  logic [15:0] rxq[$];

  always #5 clk = ~clk;

  ni_link_adapter dut (
    .clk         (clk),
    .reset       (reset),
    .ni_write_en (ni_write_en),
    .ni_waddr    (ni_waddr),
    .ni_wdata    (ni_wdata),
    .ni_wfull    (ni_wfull),
    .ni_read_en  (ni_read_en),
    .ni_rdata    (ni_rdata),
    .ni_rempty   (ni_rempty),
    .tx_flit     (tx_flit),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_flit     (rx_flit),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_count   (err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ni_write_en = 1'b0;
    ni_waddr    = '0;
    ni_wdata    = '0;
    ni_read_en  = 1'b0;
    tx_ready    = 1'b0;
    rx_flit     = '0;
    rx_valid    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send_flit(input logic [17:0] f);
    rx_flit  = f;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !rx_ready; i++) step();
    if (!rx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_flit_timeout: rx_ready=%0b want 1", rx_ready);
    end
    step();
    rx_valid = 1'b0;
    rx_flit  = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (ni_wfull !== 1'b0 || ni_rempty !== 1'b1 || ni_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_ni: wfull=%0b rempty=%0b rdata=%h want 0 1 0000",
               ni_wfull, ni_rempty, ni_rdata);
    end
    n_tests++;
    if (tx_valid !== 1'b0 || tx_flit !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_tx: valid=%0b flit=%h want 0 00000", tx_valid, tx_flit);
    end
    n_tests++;
    if (rx_ready !== 1'b1 || err_count !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_rx: ready=%0b err=%0d want 1 0", rx_ready, err_count);
    end
  endtask

  task automatic test_single_packet();
    int w;
    ni_waddr    = 16'hBCCB;
    ni_wdata    = 16'hABBA;
    ni_write_en = 1'b1;
    tx_ready    = 1'b1;
    step();
    ni_write_en = 1'b0;
    w = 0;
    while (!tx_valid && w < 8) begin
      step();
      w++;
    end
    n_tests++;
    if (tx_valid !== 1'b1 || tx_flit !== 18'h1BCCB) begin
      n_fail++;
      $display("FAIL single_head: valid=%0b flit=%h want 1 1bccb", tx_valid, tx_flit);
    end
    step();
    n_tests++;
    if (tx_valid !== 1'b1 || tx_flit !== 18'h2ABBA) begin
      n_fail++;
      $display("FAIL single_tail: valid=%0b flit=%h want 1 2abba", tx_valid, tx_flit);
    end
    step();
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: valid=%0b want 0", tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_full;
    exp_q.delete();
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ni_waddr = 16'($urandom);
      ni_wdata = 16'($urandom);
      exp_full = (k == 5);
      n_tests++;
      if (ni_wfull !== exp_full) begin
        n_fail++;
        $display("FAIL b2b_wfull_%0d: got %0b want %0b", k, ni_wfull, exp_full);
      end
      if (k < 5) begin
        exp_q.push_back({HD, ni_waddr});
        exp_q.push_back({TL, ni_wdata});
      end
      ni_write_en = 1'b1;
      step();
    end
    ni_write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_flit !== exp_q[0]) begin
        n_fail++;
        $display("FAIL b2b_hold: valid=%0b flit=%h want 1 %h", tx_valid, tx_flit, exp_q[0]);
      end
      step();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_flit !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_flit_%0d: valid=%0b flit=%h want 1 %h",
                 i, tx_valid, tx_flit, exp_q[i]);
      end
      step();
    end
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_extra: valid=%0b flit=%h want valid 0", tx_valid, tx_flit);
    end
    tx_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_rx_basic();
    send_flit(18'h1BABA);
    send_flit(18'h2CCCC);
    n_tests++;
    if (ni_rempty !== 1'b0 || ni_rdata !== 16'hCCCC) begin
      n_fail++;
      $display("FAIL rx_basic_data: rempty=%0b rdata=%h want 0 cccc", ni_rempty, ni_rdata);
    end
    ni_read_en = 1'b1;
    step();
    ni_read_en = 1'b0;
    n_tests++;
    if (ni_rempty !== 1'b1 || ni_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL rx_basic_pop: rempty=%0b rdata=%h want 1 0000", ni_rempty, ni_rdata);
    end
  endtask

  task automatic test_rx_backpressure();
    logic [15:0] d[5];
    for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      send_flit({HD, 16'($urandom)});
      send_flit({TL, d[i]});
    end
    send_flit({HD, 16'($urandom)});
    rx_flit  = {TL, d[4]};
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: rx_ready=%0b want 0", i, rx_ready);
      end
      step();
    end
    n_tests++;
    if (ni_rdata !== d[0]) begin
      n_fail++;
      $display("FAIL bp_head: rdata=%h want %h", ni_rdata, d[0]);
    end
    ni_read_en = 1'b1;
    step();
    ni_read_en = 1'b0;
    n_tests++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rx_ready=%0b want 1", rx_ready);
    end
    step();
    rx_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_tests++;
      if (ni_rempty !== 1'b0 || ni_rdata !== d[i]) begin
        n_fail++;
        $display("FAIL bp_order_%0d: rempty=%0b rdata=%h want 0 %h",
                 i, ni_rempty, ni_rdata, d[i]);
      end
      ni_read_en = 1'b1;
      step();
      ni_read_en = 1'b0;
    end
    n_tests++;
    if (ni_rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drained: rempty=%0b want 1", ni_rempty);
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] d;
    d = 16'($urandom);
    apply_reset();
    send_flit({TL, 16'($urandom)});
    send_flit({HD, 16'($urandom)});
    send_flit({HD, 16'($urandom)});
    send_flit({TL, d});
    send_flit({2'b11, 16'($urandom)});
    n_tests++;
    if (err_count !== 8'd3) begin
      n_fail++;
      $display("FAIL err_count: got %0d want 3", err_count);
    end
    n_tests++;
    if (ni_rempty !== 1'b0 || ni_rdata !== d) begin
      n_fail++;
      $display("FAIL err_word: rempty=%0b rdata=%h want 0 %h", ni_rempty, ni_rdata, d);
    end
    ni_read_en = 1'b1;
    step();
    ni_read_en = 1'b0;
    n_tests++;
    if (ni_rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL err_single: rempty=%0b want 1", ni_rempty);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      ni_waddr    = 16'($urandom);
      ni_wdata    = 16'($urandom);
      ni_write_en = 1'b1;
      step();
    end
    ni_write_en = 1'b0;
    w = 0;
    while (!tx_valid && w < 8) begin
      step();
      w++;
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    n_tests++;
    if (tx_valid !== 1'b1 || tx_flit[17:16] !== TL) begin
      n_fail++;
      $display("FAIL rst_mid_tail: valid=%0b type=%0b want 1 10", tx_valid, tx_flit[17:16]);
    end
    send_flit({HD, 16'($urandom)});
    send_flit({TL, 16'($urandom)});
    send_flit({HD, 16'($urandom)});
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (tx_valid !== 1'b0 || tx_flit !== 18'h0 || rx_ready !== 1'b1 ||
        ni_wfull !== 1'b0 || ni_rempty !== 1'b1 || ni_rdata !== 16'h0 ||
        err_count !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: txv=%0b txf=%h rxr=%0b wf=%0b re=%0b rd=%h err=%0d",
               tx_valid, tx_flit, rx_ready, ni_wfull, ni_rempty, ni_rdata, err_count);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_egress: valid=%0b want 0", tx_valid);
    end
    tx_ready = 1'b0;
    send_flit({TL, 16'($urandom)});
    n_tests++;
    if (err_count !== 8'd1 || ni_rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_rxstate: err=%0d rempty=%0b want 1 1", err_count, ni_rempty);
    end
  endtask

  task automatic test_random();
    int          exp_err;
    bit          wait_tail;
    bit          held;
    logic [17:0] held_flit;
    logic [1:0]  typ;
    int          r;
    apply_reset();
    exp_q.delete();
    rxq.delete();
    exp_err   = 0;
    wait_tail = 1'b0;
    held      = 1'b0;
    held_flit = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (held) begin
        n_tests++;
        if (tx_valid !== 1'b1 || tx_flit !== held_flit) begin
          n_fail++;
          $display("FAIL rnd_stable@%0d: valid=%0b flit=%h want 1 %h",
                   cyc, tx_valid, tx_flit, held_flit);
        end
      end
      n_tests++;
      if (ni_rempty !== (rxq.size() == 0) ||
          ni_rdata !== (rxq.size() > 0 ? rxq[0] : 16'h0)) begin
        n_fail++;
        $display("FAIL rnd_ingress@%0d: rempty=%0b rdata=%h want %0b %h", cyc,
                 ni_rempty, ni_rdata, rxq.size() == 0, rxq.size() > 0 ? rxq[0] : 16'h0);
      end
      n_tests++;
      if (rx_ready !== (!wait_tail || rxq.size() < 4)) begin
        n_fail++;
        $display("FAIL rnd_rx_ready@%0d: got %0b want %0b",
                 cyc, rx_ready, !wait_tail || rxq.size() < 4);
      end
      n_tests++;
      if (err_count !== 8'(exp_err)) begin
        n_fail++;
        $display("FAIL rnd_err@%0d: got %0d want %0d", cyc, err_count, exp_err);
      end
      ni_write_en = !ni_wfull && ($urandom_range(0, 2) == 0);
      ni_waddr    = 16'($urandom);
      ni_wdata    = 16'($urandom);
      if (ni_write_en) begin
        exp_q.push_back({HD, ni_waddr});
        exp_q.push_back({TL, ni_wdata});
      end
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        n_tests++;
        if (exp_q.size() == 0 || tx_flit !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rnd_tx@%0d: flit=%h queued=%0d", cyc, tx_flit, exp_q.size());
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      held      = tx_valid && !tx_ready;
      held_flit = tx_flit;
      ni_read_en = ($urandom_range(0, 4) < 2);
      if (ni_read_en && rxq.size() > 0) void'(rxq.pop_front());
      r        = int'($urandom_range(0, 9));
      typ      = (r < 4) ? HD : (r < 8) ? TL : (r == 8) ? 2'b00 : 2'b11;
      rx_flit  = {typ, 16'($urandom)};
      rx_valid = 1'($urandom_range(0, 1));
      if (rx_valid && rx_ready) begin
        if (wait_tail && typ == TL) begin
          rxq.push_back(rx_flit[15:0]);
          wait_tail = 1'b0;
        end else if (!wait_tail && typ == HD) begin
          wait_tail = 1'b1;
        end else begin
          exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        end
      end
      step();
    end
    idle_inputs();
    tx_ready   = 1'b1;
    ni_read_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) begin
        n_tests++;
        if (exp_q.size() == 0 || tx_flit !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rnd_drain_tx: flit=%h queued=%0d", tx_flit, exp_q.size());
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (rxq.size() > 0) begin
        n_tests++;
        if (ni_rdata !== rxq[0]) begin
          n_fail++;
          $display("FAIL rnd_drain_rx: rdata=%h want %h", ni_rdata, rxq[0]);
        end
        void'(rxq.pop_front());
      end
      step();
    end
    n_tests++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0 || ni_rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL rnd_final: left=%0d txv=%0b rempty=%0b want 0 0 1",
               exp_q.size(), tx_valid, ni_rempty);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_rx_basic();
    test_rx_backpressure();
    test_rx_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
